// File: rtl/ifu_fetch_if.sv
// Handshake bundle between the fetch unit, the next-PC block, instruction
// memory and the core. The slave modport is the fetch unit's view.
interface ifu_fetch_if;
  logic [31:0] npc;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ack;
  logic        fault;
  logic [31:0] fetch_cnt;

  modport slave (
    input  npc, imem_ready, imem_rdata, instr_ack,
    output pc, imem_req, imem_addr, instr, instr_valid, fault, fetch_cnt
  );

  modport master (
    output npc, imem_ready, imem_rdata, instr_ack,
    input  pc, imem_req, imem_addr, instr, instr_valid, fault, fetch_cnt
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction-fetch unit: holds the PC, reads one word per instruction,
// presents it to the core and advances to npc on acknowledge.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst_n,
  ifu_fetch_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic        fault_q, fault_d;
  logic        imem_req_q, imem_req_d;
  logic        instr_valid_q, instr_valid_d;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  // Next-state and datapath decode; outputs are pre-decoded from the next state
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    fetch_cnt_d = fetch_cnt_q;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (bus.imem_ready) begin
          instr_d = bus.imem_rdata;
          state_d = ST_HOLD;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (bus.instr_ack) begin
          if (is_misaligned(bus.npc)) begin
            state_d = ST_FAULT;
          end else begin
            pc_d        = bus.npc;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
            state_d     = ST_FETCH;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    imem_req_d    = (state_d == ST_FETCH);
    instr_valid_d = (state_d == ST_HOLD);
    fault_d       = (state_d == ST_FAULT);
  end

  // State, PC, instruction, counter and registered output flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= 32'h0000_0000;
      fetch_cnt_q   <= 32'h0000_0000;
      fault_q       <= 1'b0;
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      fetch_cnt_q   <= fetch_cnt_d;
      fault_q       <= fault_d;
      imem_req_q    <= imem_req_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign bus.pc          = pc_q;
  assign bus.imem_addr   = pc_q;
  assign bus.imem_req    = imem_req_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.fault       = fault_q;
  assign bus.fetch_cnt   = fetch_cnt_q;

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction-fetch unit that closes the loop around the next-PC logic. It holds the architectural PC, issues a word read to instruction memory through a req/ready handshake, and presents the fetched instruction to the decode/control stage. When the core acknowledges the instruction, the unit loads the next-PC value produced by the next-PC block. It sits between the next-PC block (upstream), instruction memory (side), and the controller/datapath (downstream), and flags misaligned next-PC values.

## Interface
- RESET_PC, 32'h0000_3000, PC value loaded on reset; first fetch address.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- npc  in  32  next-PC value from the next-PC block; sampled only on an accepted ack.
- pc  out  32  current PC; fed back to the next-PC block and to the link-address path.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  read address; equals pc.
- imem_ready  in  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  in  32  instruction word.
- instr  out  32  captured instruction.
- instr_valid  out  1  instr holds the instruction at pc.
- instr_ack  in  1  core has consumed instr; advance to npc.
- fault  out  1  sticky; set when an acked npc has npc[1:0] != 0.
- fetch_cnt  out  32  count of acked (retired) instructions.

## Operation
- States: IDLE, FETCH, HOLD, FAULT.
- Reset (rst_n=0, asynchronous) gives: state=IDLE, pc=RESET_PC, instr=0, fetch_cnt=0, fault=0, imem_req=0, instr_valid=0.
- IDLE: go to FETCH on the next edge, unconditionally.
- FETCH: imem_req=1, imem_addr=pc. The unit holds these stable until imem_ready=1. On the edge where imem_ready=1: instr<=imem_rdata, go to HOLD. imem_ready is ignored in every other state.
- HOLD: instr_valid=1, imem_req=0. On the edge where instr_ack=1:
  - If npc[1:0]==2'b00: pc<=npc, fetch_cnt<=fetch_cnt+1 (mod 2^32), go to FETCH.
  - Otherwise: pc and fetch_cnt are unchanged, fault<=1, go to FAULT.
- HOLD with instr_ack=0: hold instr, pc and instr_valid indefinitely.
- FAULT: terminal until reset. imem_req=0, instr_valid=0, fault=1, and pc keeps the PC of the faulting instruction.
- instr_ack outside HOLD is ignored; no state, pc or counter change.
- Output decode from state: imem_req=(state==FETCH), instr_valid=(state==HOLD), fault=(state==FAULT) (registered sticky bit, equivalent).
- npc is used as-is: no arithmetic on it. A wrap from 0xFFFF_FFFC to 0x0000_0000 is legal.
- fetch_cnt wraps from 0xFFFF_FFFF to 0 silently.

## Timing
- Minimum two cycles per instruction (FETCH, HOLD) with zero-wait memory (imem_ready=1 in the first FETCH cycle).
- instr_valid rises the cycle after the imem_ready cycle.
- The new pc is visible the cycle after the ack edge, together with imem_req=1.
- Memory wait states extend FETCH one cycle per imem_ready=0 cycle. imem_addr stays constant throughout.
- First imem_req after reset release: one cycle later (IDLE step), with imem_addr=RESET_PC.
- Reset asserted mid-FETCH or mid-HOLD: all outputs take their reset values immediately, without waiting for a clock edge. A pending memory response is dropped. After release, fetch restarts from RESET_PC.
- The npc combinational path may depend on pc and instr. The unit samples npc only at the ack edge, so no loop forms within a cycle.

## Test plan
- Reset release, imem_ready tied 1, instr_ack tied 1, npc=pc+4 -> imem_addr sequence 0x3000, 0x3004, 0x3008 on every other cycle; fetch_cnt increments by 1 per ack.
- imem_ready low for 3 cycles in FETCH, then data 0x2408_0005 -> imem_req high 4 cycles, imem_addr stable at 0x3000; instr=0x2408_0005 and instr_valid=1 on the next cycle.
- HOLD with instr_ack low for 5 cycles, then npc=0x0000_3040 acked -> instr/pc unchanged while waiting; then pc=0x3040 and imem_req=1.
- Acked npc=0x0000_3042 -> fault=1, state FAULT, pc stays 0x3000-series value, no further imem_req, fetch_cnt unchanged; instr_ack pulses afterwards have no effect.
- rst_n pulled low mid-HOLD (pc=0x3010) -> pc=0x3000, instr_valid=0, imem_req=0, fetch_cnt=0 without a clock edge; refetch from 0x3000 after release.
- Preload via acks to reach fetch_cnt=0xFFFF_FFFF (force/deposit), one more ack -> fetch_cnt=0. Acked npc=0xFFFF_FFFC then 0x0 -> pc wraps cleanly.
